kernel_loader: RTL and testbench

//  Write side of the 3x3 convolution kernel store. Accepts KER_TAPS coefficients in row-major

---
 rtl/kernel_pkg.sv | 21 ++
 rtl/kernel_shadow_regs.sv | 27 ++
 rtl/kernel_loader.sv | 121 ++++++++++++
 tb/tb_kernel_loader.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/kernel_pkg.sv
// Shared constants and types for the 3x3 convolution kernel store and datapath.
package kernel_pkg;

    localparam int KER_SIZE = 3;
    localparam int KER_TAPS = KER_SIZE * KER_SIZE;
    localparam int DATA_W   = 8;
    localparam int CNT_W    = $clog2(KER_TAPS);

    typedef logic [DATA_W-1:0] coef_t;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } ld_state_e;

    // Index of the final tap of a row-major kernel, sized for the tap counter.
    function automatic logic [CNT_W-1:0] last_tap_idx();
        return CNT_W'(KER_TAPS - 1);
    endfunction

endpackage

// File: rtl/kernel_shadow_regs.sv
// Shadow coefficient file: one tap written per accepted beat, all taps read in parallel
// so the loader can commit a whole kernel in a single edge.
module kernel_shadow_regs
    import kernel_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en_i,
    input  logic [CNT_W-1:0]             wr_idx_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    output logic [KER_TAPS*DATA_W-1:0]   rd_all_o
);

    logic [KER_TAPS-1:0][DATA_W-1:0] shadow_q;

    // Write one tap at the current index; reset clears the whole file.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
        end else if (wr_en_i) begin
            shadow_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_all_o = shadow_q;

endmodule

// File: rtl/kernel_loader.sv
// Kernel loader: streams KER_TAPS coefficients into a shadow file and commits them
// atomically to the active taps, so the datapath never sees a partial kernel.
module kernel_loader
    import kernel_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_abort,
    input  logic              kin_valid,
    input  logic [DATA_W-1:0] kin_data,
    output logic              kin_ready,
    output logic [DATA_W-1:0] k0,
    output logic [DATA_W-1:0] k1,
    output logic [DATA_W-1:0] k2,
    output logic [DATA_W-1:0] k3,
    output logic [DATA_W-1:0] k4,
    output logic [DATA_W-1:0] k5,
    output logic [DATA_W-1:0] k6,
    output logic [DATA_W-1:0] k7,
    output logic [DATA_W-1:0] k8,
    output logic              kernel_valid,
    output logic              load_busy
);

    ld_state_e                        state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [KER_TAPS-1:0][DATA_W-1:0]  k_q;
    logic                             kvalid_q;

    logic                             accept;
    logic                             last_beat;
    logic                             commit;
    logic [KER_TAPS*DATA_W-1:0]       shadow_all;
    logic [KER_TAPS-1:0][DATA_W-1:0]  shadow_taps;

    assign accept      = (state_q == LOAD) && kin_valid;
    assign last_beat   = accept && (cnt_q == last_tap_idx());
    assign shadow_taps = shadow_all;

    kernel_shadow_regs u_shadow (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (accept),
        .wr_idx_i  (cnt_q),
        .wr_data_i (kin_data),
        .rd_all_o  (shadow_all)
    );

    // Next-state logic: a final beat commits even if abort arrives on the same edge;
    // otherwise abort beats any non-final beat and drops the partial load.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (last_beat) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (load_abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (accept) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and tap counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Active taps: the last tap comes straight from the input beat, the rest from shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q      <= '0;
            kvalid_q <= 1'b0;
        end else if (commit) begin
            for (int i = 0; i < KER_TAPS - 1; i++) begin
                k_q[i] <= shadow_taps[i];
            end
            k_q[KER_TAPS-1] <= kin_data;
            kvalid_q        <= 1'b1;
        end
    end

    assign kin_ready    = (state_q == LOAD);
    assign load_busy    = (state_q == LOAD);
    assign kernel_valid = kvalid_q;

    assign k0 = k_q[0];
    assign k1 = k_q[1];
    assign k2 = k_q[2];
    assign k3 = k_q[3];
    assign k4 = k_q[4];
    assign k5 = k_q[5];
    assign k6 = k_q[6];
    assign k7 = k_q[7];
    assign k8 = k_q[8];

endmodule

// File: tb/tb_kernel_loader.sv
// Bench for kernel_loader: expected kernels are queued as the last beat is driven and
// compared against the active taps the cycle after.
module tb_kernel_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_start;
    logic       load_abort;
    logic       kin_valid;
    logic [7:0] kin_data;
    logic       kin_ready;
    logic [7:0] k0, k1, k2, k3, k4, k5, k6, k7, k8;
    logic       kernel_valid;
    logic       load_busy;

    logic [71:0] dut_k;
    logic [71:0] cur_k;
    logic [71:0] sb_q[$];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    assign dut_k = {k8, k7, k6, k5, k4, k3, k2, k1, k0};

    kernel_loader dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .load_abort   (load_abort),
        .kin_valid    (kin_valid),
        .kin_data     (kin_data),
        .kin_ready    (kin_ready),
        .k0           (k0),
        .k1           (k1),
        .k2           (k2),
        .k3           (k3),
        .k4           (k4),
        .k5           (k5),
        .k6           (k6),
        .k7           (k7),
        .k8           (k8),
        .kernel_valid (kernel_valid),
        .load_busy    (load_busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_taps(input string tag, input logic [71:0] exp);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("%s_k%0d", tag, i), 32'(dut_k[i*8 +: 8]), 32'(exp[i*8 +: 8]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full load of base..base+8; optional valid gaps, a stray load_start at one beat,
    // and an abort on the same edge as the final beat.
    task automatic load_kernel(input logic [7:0] base, input bit toggle,
                               input int start_at, input bit abort_last);
        logic [71:0] nk;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("busy_after_start", 32'(load_busy), 32'd1);
        for (int i = 0; i < 9; i++) begin
            if (toggle) begin
                kin_valid = 1'b0;
                tick();
                chk("ready_gap", 32'(kin_ready), 32'd1);
                chk("valid_gap", 32'(kernel_valid), 32'(cur_k != '0 ? 1 : kernel_valid));
            end
            kin_valid  = 1'b1;
            kin_data   = base + 8'(i);
            nk[i*8 +: 8] = base + 8'(i);
            load_start = (i == start_at);
            load_abort = abort_last && (i == 8);
            chk("ready_beat", 32'(kin_ready), 32'd1);
            if (i == 8) sb_q.push_back(nk);
            tick();
            load_start = 1'b0;
            load_abort = 1'b0;
            if (i < 8) chk_taps("hold_old", cur_k);
        end
        kin_valid = 1'b0;
        chk("ready_after_last", 32'(kin_ready), 32'd0);
        chk("busy_after_last", 32'(load_busy), 32'd0);
        chk("valid_after_commit", 32'(kernel_valid), 32'd1);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            cur_k = sb_q.pop_front();
            chk_taps("commit", cur_k);
        end
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; load_abort = 1'b0; kin_valid = 1'b0; kin_data = '0;
        cur_k = '0;
        tick(); tick();
        chk_taps("rst", 72'd0);
        chk("rst_valid", 32'(kernel_valid), 32'd0);
        chk("rst_ready", 32'(kin_ready), 32'd0);
        chk("rst_busy", 32'(load_busy), 32'd0);
        rst = 1'b0;
        tick();

        // 1: plain load of 1..9
        load_kernel(8'h01, 1'b0, -1, 1'b0);

        // extra valid after commit is not accepted
        kin_valid = 1'b1; kin_data = 8'hAA;
        tick(); tick();
        kin_valid = 1'b0;
        chk("no_extra_ready", 32'(kin_ready), 32'd0);
        chk_taps("no_extra", cur_k);

        // 2: reload with valid toggling; old kernel held until commit
        load_kernel(8'h10, 1'b1, -1, 1'b0);

        // 3: abort after 5 beats
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            kin_valid = 1'b1; kin_data = 8'h80 + 8'(i); tick();
        end
        kin_valid = 1'b0; load_abort = 1'b1; tick(); load_abort = 1'b0;
        chk("abort_busy", 32'(load_busy), 32'd0);
        chk("abort_ready", 32'(kin_ready), 32'd0);
        chk("abort_valid", 32'(kernel_valid), 32'd1);
        chk_taps("abort_keep", cur_k);
        load_kernel(8'h20, 1'b0, -1, 1'b0);

        // abort in IDLE is ignored
        load_abort = 1'b1; tick(); load_abort = 1'b0;
        chk("idle_abort_busy", 32'(load_busy), 32'd0);
        chk("idle_abort_valid", 32'(kernel_valid), 32'd1);

        // 4: abort on the same edge as the final beat
        load_kernel(8'h30, 1'b0, -1, 1'b1);

        // 5: reset after 4 beats
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            kin_valid = 1'b1; kin_data = 8'h90 + 8'(i); tick();
        end
        rst = 1'b1; tick();
        kin_valid = 1'b0; rst = 1'b0;
        cur_k = '0;
        chk_taps("midrst", 72'd0);
        chk("midrst_valid", 32'(kernel_valid), 32'd0);
        chk("midrst_ready", 32'(kin_ready), 32'd0);

        // 6: valid in IDLE is ignored, stray load_start mid-load does not restart
        kin_valid = 1'b1; kin_data = 8'hEE;
        tick(); tick(); tick();
        kin_valid = 1'b0;
        chk("idle_valid_ready", 32'(kin_ready), 32'd0);
        chk("idle_valid_kv", 32'(kernel_valid), 32'd0);
        chk_taps("idle_valid", 72'd0);
        load_kernel(8'h40, 1'b0, 3, 1'b0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
